// File: rtl/c6288_chk_pkg.sv
// Shared types and widths for the C6288 multiplier checker.
// Imported by the shift-add datapath and the checker FSM.
package c6288_chk_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int CNT_W  = 8;
    localparam int STEP_W = $clog2(OP_W);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        CMP
    } state_t;

    // Error counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_mult16.sv
// Sequential 16x16 unsigned shift-add multiplier, one step per clock.
// load captures operands; last flags the final step.
module seq_mult16
    import c6288_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] acc,
    output logic              last
);

    logic [PROD_W-1:0] mcand;
    logic [OP_W-1:0]   mplier;
    logic [STEP_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{(PROD_W-OP_W){1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign last = step && (cnt == STEP_W'(OP_W - 1));

endmodule

// File: rtl/mult_checker.sv
// Checks a C6288 multiplier product against a serial golden reference.
// Counts mismatches and raises a sticky trojan alarm at a threshold.
module mult_checker
    import c6288_chk_pkg::*;
#(
    parameter int ERR_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    input  logic [PROD_W-1:0] dut_p,
    input  logic              clr_err,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [PROD_W-1:0] ref_p,
    output logic [CNT_W-1:0]  err_count,
    output logic              trojan_flag
);

    state_t            state;
    logic [PROD_W-1:0] cap_p;
    logic [PROD_W-1:0] acc;
    logic              last;
    logic              load;
    logic              step;
    logic              miss;
    logic [CNT_W-1:0]  nxt_cnt;

    assign load    = (state == IDLE) && start;
    assign step    = (state == MULT);
    assign miss    = (acc != cap_p);
    assign nxt_cnt = sat_inc(err_count);
    assign busy    = (state != IDLE);

    seq_mult16 u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a     (op_a),
        .b     (op_b),
        .acc   (acc),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cap_p       <= '0;
            done        <= 1'b0;
            mismatch    <= 1'b0;
            ref_p       <= '0;
            err_count   <= '0;
            trojan_flag <= 1'b0;
        end else begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cap_p <= dut_p;
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (last) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    ref_p    <= acc;
                    done     <= 1'b1;
                    mismatch <= miss;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A clear on the completion edge beats the new mismatch.
            if (clr_err) begin
                err_count   <= '0;
                trojan_flag <= 1'b0;
            end else if (state == CMP && miss) begin
                err_count <= nxt_cnt;
                if (nxt_cnt >= CNT_W'(ERR_THRESH)) begin
                    trojan_flag <= 1'b1;
                end
            end
        end
    end

endmodule
